// File: rtl/log_rd_port_arbiter.sv
// Two-reader round-robin arbiter for the circular log buffer read port.
// A tag FIFO remembers who issued each in-flight read for response steering.
module log_rd_port_arbiter #(
    parameter int ADDR_W             = 8,
    parameter int RESP_DATA_STRUCT_W = 64,
    parameter int MAX_OUTSTANDING    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd0_req_val,
    input  logic [ADDR_W-1:0]             rd0_req_addr,
    output logic                          rd0_req_rdy,
    output logic                          rd0_resp_val,
    output logic [RESP_DATA_STRUCT_W-1:0] rd0_resp_data,
    input  logic                          rd1_req_val,
    input  logic [ADDR_W-1:0]             rd1_req_addr,
    output logic                          rd1_req_rdy,
    output logic                          rd1_resp_val,
    output logic [RESP_DATA_STRUCT_W-1:0] rd1_resp_data,
    output logic                          log_rd_req_val,
    output logic [ADDR_W-1:0]             log_rd_req_addr,
    input  logic                          log_rd_resp_val,
    input  logic [RESP_DATA_STRUCT_W-1:0] log_rd_resp_data,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_cnt,
    output logic                          spurious_resp
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_tag [MAX_OUTSTANDING];
    logic             r_last_grant;
    logic             r_spur;

    logic              w_credit;
    logic              w_gnt1;
    logic              w_rdy0;
    logic              w_rdy1;
    logic              w_issue;
    logic [ADDR_W-1:0] w_addr;
    logic              w_empty;
    logic              w_pop;
    logic              w_head;

    assign w_credit = r_cnt < CNT_W'(MAX_OUTSTANDING);

    // Requester 1 wins alone, or on contention when 0 was granted last.
    assign w_gnt1  = rd1_req_val && (!rd0_req_val || !r_last_grant);
    assign w_rdy0  = w_credit && (!rd1_req_val || r_last_grant);
    assign w_rdy1  = w_credit && (!rd0_req_val || !r_last_grant);
    assign w_issue = w_credit && (rd0_req_val || rd1_req_val);
    assign w_addr  = !w_issue ? '0 :
                     (w_gnt1 ? rd1_req_addr : rd0_req_addr);

    assign w_empty = (r_cnt == '0);
    assign w_pop   = log_rd_resp_val && !w_empty;
    assign w_head  = r_tag[r_rd_ptr];

    // Combinational outputs are forced low while reset is held.
    assign rd0_req_rdy     = w_rdy0 && rst_n;
    assign rd1_req_rdy     = w_rdy1 && rst_n;
    assign log_rd_req_val  = w_issue && rst_n;
    assign log_rd_req_addr = w_addr & {ADDR_W{rst_n}};
    assign rd0_resp_val    = w_pop && !w_head && rst_n;
    assign rd1_resp_val    = w_pop && w_head && rst_n;
    assign rd0_resp_data   = log_rd_resp_data & {RESP_DATA_STRUCT_W{rst_n}};
    assign rd1_resp_data   = log_rd_resp_data & {RESP_DATA_STRUCT_W{rst_n}};
    assign outstanding_cnt = r_cnt;
    assign spurious_resp   = r_spur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_tag        <= '{default: 1'b0};
            r_last_grant <= 1'b1;
            r_spur       <= 1'b0;
        end else begin
            if (w_issue) begin
                r_tag[r_wr_ptr] <= w_gnt1;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                r_last_grant    <= w_gnt1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_issue && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!w_issue && w_pop) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (log_rd_resp_val && w_empty) begin
                r_spur <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_log_rd_port_arbiter.sv
// Randomised bench for log_rd_port_arbiter against a queue-based
// model of grants, credits and in-order response ownership.
module tb_log_rd_port_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 64;
    localparam int MAXO = 4;
    localparam int CW   = $clog2(MAXO) + 1;
    localparam int EW   = 6 + AW + CW + 2 * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd0_req_val = 1'b0;
    logic [AW-1:0] rd0_req_addr = '0;
    logic          rd0_req_rdy;
    logic          rd0_resp_val;
    logic [DW-1:0] rd0_resp_data;
    logic          rd1_req_val = 1'b0;
    logic [AW-1:0] rd1_req_addr = '0;
    logic          rd1_req_rdy;
    logic          rd1_resp_val;
    logic [DW-1:0] rd1_resp_data;
    logic          log_rd_req_val;
    logic [AW-1:0] log_rd_req_addr;
    logic          log_rd_resp_val = 1'b0;
    logic [DW-1:0] log_rd_resp_data = '0;
    logic [CW-1:0] outstanding_cnt;
    logic          spurious_resp;

    always #5 clk = ~clk;

    log_rd_port_arbiter #(
        .ADDR_W(AW), .RESP_DATA_STRUCT_W(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd0_req_val(rd0_req_val), .rd0_req_addr(rd0_req_addr),
        .rd0_req_rdy(rd0_req_rdy), .rd0_resp_val(rd0_resp_val),
        .rd0_resp_data(rd0_resp_data),
        .rd1_req_val(rd1_req_val), .rd1_req_addr(rd1_req_addr),
        .rd1_req_rdy(rd1_req_rdy), .rd1_resp_val(rd1_resp_val),
        .rd1_resp_data(rd1_resp_data),
        .log_rd_req_val(log_rd_req_val), .log_rd_req_addr(log_rd_req_addr),
        .log_rd_resp_val(log_rd_resp_val), .log_rd_resp_data(log_rd_resp_data),
        .outstanding_cnt(outstanding_cnt), .spurious_resp(spurious_resp)
    );

    wire [EW-1:0] w_obs = {rd0_req_rdy, rd1_req_rdy, rd0_resp_val,
                           rd1_resp_val, log_rd_req_val, log_rd_req_addr,
                           outstanding_cnt, spurious_resp,
                           rd0_resp_data, rd1_resp_data};

    typedef struct { logic [DW-1:0] d; int due; } mem_t;

    int   m_own[$];
    int   m_last = 1;
    bit   m_spur = 0;
    mem_t mem_q[$];
    int   last_due = 0;
    int   cyc = 0;
    bit   stall = 0;
    int   lat_min = 1;
    int   lat_max = 1;

    logic [EW-1:0] e_vec;
    bit e_iss;
    int e_g;
    bit e_rv;
    int n_vec = 0;
    int n_bad = 0;

    function automatic int pick(bit a, bit b);
        if (a && b) return 1 - m_last;
        if (a) return 0;
        if (b) return 1;
        return -1;
    endfunction

    task automatic drive(input bit v0, input logic [AW-1:0] a0,
                         input bit v1, input logic [AW-1:0] a1,
                         input bit spur);
        logic [DW-1:0] rdat;
        bit credit, rdy0, rdy1, rv0, rv1;
        logic [AW-1:0] addr;
        rdat = {$urandom, $urandom};
        e_rv = 0;
        if (spur) begin
            e_rv = 1;
        end else if (!stall && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            e_rv = 1;
            rdat = mem_q[0].d;
        end
        rd0_req_val = v0; rd0_req_addr = a0;
        rd1_req_val = v1; rd1_req_addr = a1;
        log_rd_resp_val = e_rv; log_rd_resp_data = rdat;
        #4;
        credit = m_own.size() < MAXO;
        e_g    = pick(v0, v1);
        rdy0   = credit && pick(1'b1, v1) == 0;
        rdy1   = credit && pick(v0, 1'b1) == 1;
        e_iss  = credit && (v0 || v1);
        addr   = !e_iss ? '0 : (e_g == 1 ? a1 : a0);
        rv0    = e_rv && m_own.size() > 0 && m_own[0] == 0;
        rv1    = e_rv && m_own.size() > 0 && m_own[0] == 1;
        e_vec  = {rdy0, rdy1, rv0, rv1, e_iss, addr,
                  CW'(m_own.size()), m_spur, rdat, rdat};
        if (!rst_n) begin
            e_vec = '0;
            e_iss = 0;
        end
    endtask

    task automatic commit();
        int due;
        @(posedge clk);
        if (!rst_n) begin
            m_own.delete();
            mem_q.delete();
            m_last = 1;
            m_spur = 0;
            last_due = 0;
        end else begin
            if (e_rv && m_own.size() > 0) begin
                void'(m_own.pop_front());
                void'(mem_q.pop_front());
            end else if (e_rv) begin
                m_spur = 1;
            end
            if (e_iss) begin
                m_own.push_back(e_g);
                m_last = e_g;
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{d: {$urandom, $urandom}, due: due});
            end
        end
        cyc++;
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        commit();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, AW'($urandom), 1, AW'($urandom), 1);
            n_vec++;
            if (w_obs !== e_vec) begin
                n_bad++;
                $display("FAIL reset_hold got %h want %h", w_obs, e_vec);
            end
            commit();
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        n_vec++;
        if (w_obs !== e_vec) begin
            n_bad++;
            $display("FAIL reset_idle got %h want %h", w_obs, e_vec);
        end
        commit();
    endtask

    task automatic test_single();
        logic [AW-1:0] seq [6] = '{8'h05, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00};
        reset_dut();
        lat_min = 2; lat_max = 2; stall = 0;
        for (int i = 0; i < 6; i++) begin
            drive(i < 2, seq[i], 0, 0, 0);
            n_vec++;
            if (w_obs !== e_vec) begin
                n_bad++;
                $display("FAIL single c%0d got %h want %h", i, w_obs, e_vec);
            end
            commit();
        end
    endtask

    task automatic test_contention();
        int k0 = 0;
        int k1 = 0;
        reset_dut();
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 16; i++) begin
            drive(1, AW'(8'h10 + k0), 1, AW'(8'h80 + k1), 0);
            n_vec++;
            if (w_obs !== e_vec) begin
                n_bad++;
                $display("FAIL contention c%0d got %h want %h", i, w_obs, e_vec);
            end
            if (e_iss && e_g == 0) k0++;
            if (e_iss && e_g == 1) k1++;
            commit();
        end
    endtask

    task automatic test_credit();
        reset_dut();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 16; i++) begin
            stall = !(i == 6 || i >= 10);
            drive(i < 10, AW'(8'h20 + i), 0, 0, 0);
            n_vec++;
            if (w_obs !== e_vec) begin
                n_bad++;
                $display("FAIL credit c%0d got %h want %h", i, w_obs, e_vec);
            end
            commit();
        end
        stall = 0;
    endtask

    task automatic test_random();
        reset_dut();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(3, 0) == 0);
            drive($urandom_range(1, 0) == 1, AW'($urandom),
                  $urandom_range(1, 0) == 1, AW'($urandom), 0);
            n_vec++;
            if (w_obs !== e_vec) begin
                n_bad++;
                $display("FAIL random c%0d got %h want %h", i, w_obs, e_vec);
            end
            commit();
        end
        stall = 0;
    endtask

    task automatic test_spurious();
        for (int i = 0; i < 30 && mem_q.size() > 0; i++) begin
            drive(0, 0, 0, 0, 0);
            commit();
        end
        n_vec++;
        if (mem_q.size() != 0) begin
            n_bad++;
            $display("FAIL spur_drain got %0d want 0", mem_q.size());
        end
        lat_min = 1; lat_max = 2;
        for (int i = 0; i < 14; i++) begin
            drive(i > 2 && i < 8, AW'(8'h40 + i), i > 4 && i < 9,
                  AW'(8'hc0 + i), i == 0);
            n_vec++;
            if (w_obs !== e_vec) begin
                n_bad++;
                $display("FAIL spurious c%0d got %h want %h", i, w_obs, e_vec);
            end
            commit();
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, AW'(8'h50 + i), 0, 0, 0);
            commit();
        end
        drive(1, 8'h60, 1, 8'h61, 0);
        n_vec++;
        if (w_obs !== e_vec) begin
            n_bad++;
            $display("FAIL mid_pre got %h want %h", w_obs, e_vec);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (w_obs !== '0) begin
            n_bad++;
            $display("FAIL mid_async got %h want 0", w_obs);
        end
        commit();
        rst_n = 1'b1;
        stall = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, AW'(8'h33 + i), 1, AW'(8'h44 + i), 0);
            n_vec++;
            if (w_obs !== e_vec) begin
                n_bad++;
                $display("FAIL mid_post c%0d got %h want %h", i, w_obs, e_vec);
            end
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_credit();
        test_random();
        test_spurious();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
